stopwatch_lap_core: RTL and testbench
=====================================

// Module: stopwatch_lap_core
// PURPOSE
//  Parametrised stopwatch control and datapath with hours/min/sec/sub-second counting and a LAP_DEPTH lap buffer.
//  Sits between the upstream btn_debounce instances (single-cycle pulse inputs) and the display path.
//  Supports run/stop, clear, lap capture and stopped-state lap recall.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency; CLK_HZ % TICK_HZ == 0
//  TICK_HZ    100          sub-second tick rate (100 gives centiseconds); range 2..128
//  LAP_DEPTH  4            number of lap registers; range 1..16
//  HOUR_MAX   24           hour counter modulus; range 1..32
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-low
//  i_runstop  in   1   debounced 1-cycle pulse: toggle RUN/STOP
//  i_clear    in   1   debounced 1-cycle pulse: clear time and lap buffer (honoured only in STOP)
//  i_lap      in   1   debounced 1-cycle pulse: capture current time (honoured only in RUN)
//  i_recall   in   1   debounced 1-cycle pulse: step lap view (honoured only in STOP)
//  o_sub      out  SW  sub-second count 0..TICK_HZ-1; SW = $clog2(TICK_HZ)
//  o_sec      out  6   seconds 0..59
//  o_min      out  6   minutes 0..59
//  o_hour     out  5   hours 0..HOUR_MAX-1
//  o_running  out  1   1 in RUN
//  o_view_lap out  1   1 while a stored lap is displayed instead of live time
//  o_lap_idx  out  LW  index of the displayed lap; LW = max(1,$clog2(LAP_DEPTH))
//  o_lap_cnt  out  LW+1  number of laps stored, 0..LAP_DEPTH
//  o_lap_full out  1   o_lap_cnt == LAP_DEPTH
// BEHAVIOUR
//  Reset (rst=0, async): state STOP, all counters/lap regs/tick prescaler 0, all outputs 0.
//  Prescaler counts 0..CLK_HZ/TICK_HZ-1 in RUN only; it holds its value in STOP.
//   The tick is a 1-cycle strobe on terminal count.
//  Time chain on tick: sub -> sec(60) -> min(60) -> hour(HOUR_MAX).
//   Carries ripple in the same cycle (combinational carry, registered update).
//   HOUR_MAX-1:59:59:TICK_HZ-1 wraps to all zero and RUN continues.
//  FSM states STOP, RUN:
//   STOP --i_runstop--> RUN: clears o_view_lap. Timing resumes from held values; prescaler is not reset.
//   RUN --i_runstop--> STOP: counters freeze on that edge.
//   STOP & i_clear: time, prescaler, lap_cnt, lap_idx and view all cleared in one cycle. Stays in STOP.
//   RUN & i_clear: ignored.
//  Priority within one cycle: i_clear > i_runstop > i_lap > i_recall.
//   Only the highest-priority pulse valid in the current state acts; the others are dropped.
//  Lap capture (RUN, i_lap): if !o_lap_full, write live {hour,min,sec,sub} to lap[lap_cnt] and increment lap_cnt.
//   If full, drop silently; no overwrite.
//   The captured value is the registered time before any tick in the same cycle, so a tick-coincident capture stores the pre-increment value.
//  Recall (STOP, i_recall):
//   If lap_cnt == 0, ignore.
//   If live view, show lap[0].
//   If viewing idx < lap_cnt-1, show idx+1.
//   If viewing the last lap, return to live view with idx = 0.
//  Output mux (combinational from registers): o_view_lap ? lap[o_lap_idx] : live time. Zero latency from the register update.
//  The outputs update the cycle after the accepting pulse edge; registered state plus combinational mux.
//  Async reset asserted mid-RUN: immediate return to reset values. No pulse is remembered across reset.
// STRUCTURE
//  Shared package/include (stopwatch_defs): state encodings ST_STOP/ST_RUN, the field widths, and the 60/59 constants.
//  Sub-module tick_gen #(CLK_HZ,TICK_HZ): prescaler with en and sync clr, output tick strobe.
//  Time chain, FSM, lap register file and view mux are in this module.
// TESTING
//  Use CLK_HZ=1000, TICK_HZ=100 (10 clk/tick) and LAP_DEPTH=4 unless noted.
//  1 Reset then runstop pulse, wait 1000 clk -> o_sub=0,o_sec=1,o_running=1. A second runstop then holds values for 500 clk.
//  2 Preload by running to 23:59:59:99 with HOUR_MAX=24, then 1 more tick -> all fields 0, o_running still 1.
//  3 In RUN, lap pulses at sub=12, 40, 77, then 2 more -> lap_cnt=4, o_lap_full=1. The 5th pulse leaves lap[3] unchanged.
//  4 Stop, then 5 recall pulses -> view lap0,1,2,3, then live (o_view_lap=0, idx=0). Recall in RUN has no effect.
//  5 Same-cycle pulses: clear+runstop in STOP -> cleared, stays STOP. Lap coincident with tick at sub=9 -> stores sub=9.
//  6 rst low for 1 clk mid-RUN at 00:00:03:50 -> all outputs 0 asynchronously, STOP after release. Clear in RUN is ignored.

Source files
------------

// File: rtl/stopwatch_lap_core_pkg.sv
// Shared definitions for the stopwatch core: FSM encodings, time field
// widths and the modulus constants of the seconds/minutes counters.
package stopwatch_lap_core_pkg;

  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef logic [SEC_W-1:0]  sec_t;
  typedef logic [MIN_W-1:0]  min_t;
  typedef logic [HOUR_W-1:0] hour_t;

  localparam sec_t SEC_LAST = 6'd59;
  localparam min_t MIN_LAST = 6'd59;

  // Width of the sub-second field for a given tick rate.
  function automatic int sub_width(input int tick_hz);
    return $clog2(tick_hz);
  endfunction

  // Width of a lap index; a single-entry buffer still gets one bit.
  function automatic int lap_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_lap_core_if.sv
// Button pulses in, displayed time and lap status out. The master side is
// the button/display glue, the slave side is the stopwatch core.
interface stopwatch_lap_core_if #(
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4
);
  import stopwatch_lap_core_pkg::*;

  localparam int SW = sub_width(TICK_HZ);
  localparam int LW = lap_width(LAP_DEPTH);

  logic          i_runstop;
  logic          i_clear;
  logic          i_lap;
  logic          i_recall;
  logic [SW-1:0] o_sub;
  sec_t          o_sec;
  min_t          o_min;
  hour_t         o_hour;
  logic          o_running;
  logic          o_view_lap;
  logic [LW-1:0] o_lap_idx;
  logic [LW:0]   o_lap_cnt;
  logic          o_lap_full;

  modport master (
    output i_runstop, i_clear, i_lap, i_recall,
    input  o_sub, o_sec, o_min, o_hour, o_running,
    input  o_view_lap, o_lap_idx, o_lap_cnt, o_lap_full
  );

  modport slave (
    input  i_runstop, i_clear, i_lap, i_recall,
    output o_sub, o_sec, o_min, o_hour, o_running,
    output o_view_lap, o_lap_idx, o_lap_cnt, o_lap_full
  );

endinterface

// File: rtl/stopwatch_lap_core_tick_gen.sv
// Sub-second prescaler: divides clk down to TICK_HZ and emits a one-cycle
// tick strobe on terminal count. The count holds while en is low so a
// stopped watch resumes mid-tick.
module stopwatch_lap_core_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LAST = cnt_t'(DIV - 1);

  cnt_t cnt_q;

  assign tick = en && (cnt_q == LAST);

  // Prescaler: synchronous clear wins, otherwise count only while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch control and datapath: run/stop FSM, hour/min/sec/sub-second
// chain, lap register file and the live/lap display mux.
module stopwatch_lap_core #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4,
  parameter int HOUR_MAX  = 24
) (
  input logic                 clk,
  input logic                 rst,
  stopwatch_lap_core_if.slave sw
);
  import stopwatch_lap_core_pkg::*;

  localparam int SW = sub_width(TICK_HZ);
  localparam int LW = lap_width(LAP_DEPTH);
  localparam int TW = HOUR_W + MIN_W + SEC_W + SW;

  typedef logic [SW-1:0] sub_t;
  typedef logic [LW-1:0] idx_t;
  typedef logic [LW:0]   cnt_t;
  typedef logic [TW-1:0] time_t;

  localparam sub_t  SUB_LAST     = sub_t'(TICK_HZ - 1);
  localparam hour_t HOUR_LAST    = hour_t'(HOUR_MAX - 1);
  localparam cnt_t  LAP_FULL_CNT = cnt_t'(LAP_DEPTH);

  logic [0:0] state_q;
  sub_t       sub_q;
  sec_t       sec_q;
  min_t       min_q;
  hour_t      hour_q;
  time_t      lap_mem [LAP_DEPTH];
  cnt_t       lap_cnt_q;
  idx_t       lap_idx_q;
  logic       view_q;

  logic  running;
  logic  lap_full;
  logic  tick;
  logic  clear_act;
  logic  runstop_act;
  logic  lap_act;
  logic  recall_act;
  logic  sub_wrap;
  logic  sec_wrap;
  logic  min_wrap;
  time_t live_time;
  time_t shown;

  assign running  = (state_q == ST_RUN);
  assign lap_full = (lap_cnt_q == LAP_FULL_CNT);

  // Clear is only meaningful when stopped, and once it acts nothing else
  // does. In RUN the highest valid pulse is runstop, then lap; recall only
  // exists in STOP below clear and runstop.
  assign clear_act   = !running && sw.i_clear;
  assign runstop_act = !clear_act && sw.i_runstop;
  assign lap_act     = running && !sw.i_runstop && sw.i_lap && !lap_full;
  assign recall_act  = !running && !sw.i_clear && !sw.i_runstop && sw.i_recall
                       && (lap_cnt_q != '0);

  // The prescaler is gated off on the stopping edge so time freezes there.
  stopwatch_lap_core_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (running && !sw.i_runstop),
    .clr  (clear_act),
    .tick (tick)
  );

  assign sub_wrap = tick && (sub_q == SUB_LAST);
  assign sec_wrap = sub_wrap && (sec_q == SEC_LAST);
  assign min_wrap = sec_wrap && (min_q == MIN_LAST);

  assign live_time = {hour_q, min_q, sec_q, sub_q};

  // Run/stop FSM toggles on every accepted runstop pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STOP;
    end else if (runstop_act) begin
      state_q <= running ? ST_STOP : ST_RUN;
    end
  end

  // Time chain: carries are resolved combinationally, every field updates together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (clear_act) begin
      sub_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (tick) begin
      sub_q <= sub_wrap ? '0 : sub_q + 1'b1;
      if (sub_wrap) begin
        sec_q <= sec_wrap ? '0 : sec_q + 1'b1;
      end
      if (sec_wrap) begin
        min_q <= min_wrap ? '0 : min_q + 1'b1;
      end
      if (min_wrap) begin
        hour_q <= (hour_q == HOUR_LAST) ? '0 : hour_q + 1'b1;
      end
    end
  end

  // Lap file: captures the registered time, so a tick on the same edge is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lap_mem[i] <= '0;
      end
      lap_cnt_q <= '0;
    end else if (clear_act) begin
      lap_cnt_q <= '0;
    end else if (lap_act) begin
      lap_mem[lap_cnt_q[LW-1:0]] <= live_time;
      lap_cnt_q                  <= lap_cnt_q + 1'b1;
    end
  end

  // Lap view stepping: live -> lap0 -> ... -> last lap -> live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      view_q    <= 1'b0;
      lap_idx_q <= '0;
    end else if (clear_act) begin
      view_q    <= 1'b0;
      lap_idx_q <= '0;
    end else if (runstop_act && !running) begin
      view_q <= 1'b0;
    end else if (recall_act) begin
      if (!view_q) begin
        view_q    <= 1'b1;
        lap_idx_q <= '0;
      end else if (({1'b0, lap_idx_q} + 1'b1) < lap_cnt_q) begin
        lap_idx_q <= lap_idx_q + 1'b1;
      end else begin
        view_q    <= 1'b0;
        lap_idx_q <= '0;
      end
    end
  end

  // Display mux: either the selected lap or the live counters.
  always_comb begin
    shown = live_time;
    if (view_q) begin
      shown = lap_mem[lap_idx_q];
    end
  end

  assign sw.o_sub      = shown[SW-1:0];
  assign sw.o_sec      = shown[SW +: SEC_W];
  assign sw.o_min      = shown[SW + SEC_W +: MIN_W];
  assign sw.o_hour     = shown[TW-1 -: HOUR_W];
  assign sw.o_running  = running;
  assign sw.o_view_lap = view_q;
  assign sw.o_lap_idx  = lap_idx_q;
  assign sw.o_lap_cnt  = lap_cnt_q;
  assign sw.o_lap_full = lap_full;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Bench for stopwatch_lap_core. dut0 uses the 10 clk/tick setup; dut1 is a
// fast two-hour watch (one tick per clock) so the full wrap fits in the run.
// The reference keeps time as a plain tick count and derives the fields with
// division, and holds laps as a list of tick counts.
module tb_stopwatch_lap_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   asserts = 0;
  int   fails = 0;

  stopwatch_lap_core_if #(.TICK_HZ(100), .LAP_DEPTH(4)) bus0 ();
  stopwatch_lap_core_if #(.TICK_HZ(2),   .LAP_DEPTH(2)) bus1 ();

  stopwatch_lap_core #(
    .CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(4), .HOUR_MAX(24)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .sw  (bus0)
  );

  stopwatch_lap_core #(
    .CLK_HZ(2), .TICK_HZ(2), .LAP_DEPTH(2), .HOUR_MAX(2)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .sw  (bus1)
  );

  always #5 clk = ~clk;

  // Reference model state, one slot per DUT.
  int m_run   [2];
  int m_ticks [2];
  int m_phase [2];
  int m_view  [2];
  int m_idx   [2];
  int m_cnt   [2];
  int m_lap   [2][16];

  function automatic int divOf(input int d);   return (d == 0) ? 10 : 1;   endfunction
  function automatic int hzOf(input int d);    return (d == 0) ? 100 : 2;  endfunction
  function automatic int depthOf(input int d); return (d == 0) ? 4 : 2;    endfunction
  function automatic int hmaxOf(input int d);  return (d == 0) ? 24 : 2;   endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_ticks[d] = 0; m_phase[d] = 0;
      m_view[d] = 0; m_idx[d] = 0; m_cnt[d] = 0;
      for (int k = 0; k < 16; k++) m_lap[d][k] = 0;
    end
  endfunction

  function automatic void modelStep(input int d, input logic rs, input logic cl,
                                    input logic lp, input logic rc);
    if (m_run[d] == 0) begin
      if (cl) begin
        m_ticks[d] = 0; m_phase[d] = 0; m_cnt[d] = 0; m_view[d] = 0; m_idx[d] = 0;
      end else if (rs) begin
        m_run[d] = 1; m_view[d] = 0;
      end else if (rc && m_cnt[d] > 0) begin
        if (m_view[d] == 0) begin
          m_view[d] = 1; m_idx[d] = 0;
        end else if (m_idx[d] < m_cnt[d] - 1) begin
          m_idx[d] = m_idx[d] + 1;
        end else begin
          m_view[d] = 0; m_idx[d] = 0;
        end
      end
    end else begin
      if (rs) begin
        m_run[d] = 0;
      end else begin
        if (lp && m_cnt[d] < depthOf(d)) begin
          m_lap[d][m_cnt[d]] = m_ticks[d];
          m_cnt[d] = m_cnt[d] + 1;
        end
        m_phase[d] = m_phase[d] + 1;
        if (m_phase[d] == divOf(d)) begin
          m_phase[d] = 0;
          m_ticks[d] = (m_ticks[d] + 1) % (hzOf(d) * 3600 * hmaxOf(d));
        end
      end
    end
  endfunction

  // Advance the reference on every clock edge the DUTs see out of reset.
  always @(posedge clk) begin
    if (rst) begin
      modelStep(0, bus0.i_runstop, bus0.i_clear, bus0.i_lap, bus0.i_recall);
      modelStep(1, bus1.i_runstop, bus1.i_clear, bus1.i_lap, bus1.i_recall);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input int d, input string tag);
    int t;
    int hz;
    logic [31:0] o_sub, o_sec, o_min, o_hour, o_run, o_view, o_idx, o_cnt, o_full;
    hz = hzOf(d);
    t  = (m_view[d] != 0) ? m_lap[d][m_idx[d]] : m_ticks[d];
    if (d == 0) begin
      o_sub = 32'(bus0.o_sub); o_sec = 32'(bus0.o_sec); o_min = 32'(bus0.o_min);
      o_hour = 32'(bus0.o_hour); o_run = 32'(bus0.o_running); o_view = 32'(bus0.o_view_lap);
      o_idx = 32'(bus0.o_lap_idx); o_cnt = 32'(bus0.o_lap_cnt); o_full = 32'(bus0.o_lap_full);
    end else begin
      o_sub = 32'(bus1.o_sub); o_sec = 32'(bus1.o_sec); o_min = 32'(bus1.o_min);
      o_hour = 32'(bus1.o_hour); o_run = 32'(bus1.o_running); o_view = 32'(bus1.o_view_lap);
      o_idx = 32'(bus1.o_lap_idx); o_cnt = 32'(bus1.o_lap_cnt); o_full = 32'(bus1.o_lap_full);
    end
    chk({tag, ".sub"},  o_sub,  32'(t % hz));
    chk({tag, ".sec"},  o_sec,  32'((t / hz) % 60));
    chk({tag, ".min"},  o_min,  32'((t / (hz * 60)) % 60));
    chk({tag, ".hour"}, o_hour, 32'(t / (hz * 3600)));
    chk({tag, ".run"},  o_run,  32'(m_run[d]));
    chk({tag, ".view"}, o_view, 32'(m_view[d]));
    chk({tag, ".idx"},  o_idx,  32'(m_idx[d]));
    chk({tag, ".cnt"},  o_cnt,  32'(m_cnt[d]));
    chk({tag, ".full"}, o_full, (m_cnt[d] == depthOf(d)) ? 32'd1 : 32'd0);
  endtask

  task automatic setInputs(input int d, input logic rs, input logic cl,
                           input logic lp, input logic rc);
    if (d == 0) begin
      bus0.i_runstop = rs; bus0.i_clear = cl; bus0.i_lap = lp; bus0.i_recall = rc;
    end else begin
      bus1.i_runstop = rs; bus1.i_clear = cl; bus1.i_lap = lp; bus1.i_recall = rc;
    end
  endtask

  // Called at a falling edge: hold the pulses across one rising edge.
  task automatic applyStimulus(input int d, input logic rs, input logic cl,
                               input logic lp, input logic rc);
    setInputs(d, rs, cl, lp, rc);
    @(negedge clk);
    setInputs(d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitFor(input int d, input int ticks, input int phase, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (m_ticks[d] == ticks && (phase < 0 || m_phase[d] == phase)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    asserts++;
    assert (found) else begin
      fails++;
      $error("FAIL wait_dut%0d: observed timeout expected tick %0d", d, ticks);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed no end expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expIdx  [5];
    int expView [5];
    int lapAt   [3];
    expIdx  = '{0, 1, 2, 3, 0};
    expView = '{1, 1, 1, 1, 0};
    lapAt   = '{12, 40, 77};
    setInputs(0, 1'b0, 1'b0, 1'b0, 1'b0);
    setInputs(1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset
    #2 rst = 1'b0;
    modelReset();
    #1;
    checkOutput(0, "reset0");
    checkOutput(1, "reset1");
    idle(2);
    rst = 1'b1;

    // 1: one second of running, then stop and hold
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1000);
    checkOutput(0, "t1_run");
    chk("t1_sub", 32'(bus0.o_sub), 32'd0);
    chk("t1_sec", 32'(bus0.o_sec), 32'd1);
    chk("t1_running", 32'(bus0.o_running), 32'd1);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(500);
    checkOutput(0, "t1_hold");
    chk("t1_hold_sec", 32'(bus0.o_sec), 32'd1);
    chk("t1_hold_sub", 32'(bus0.o_sub), 32'd0);

    // 2: full wrap on the fast watch
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(14399);
    checkOutput(1, "t2_last");
    chk("t2_last_hour", 32'(bus1.o_hour), 32'd1);
    chk("t2_last_min",  32'(bus1.o_min),  32'd59);
    chk("t2_last_sec",  32'(bus1.o_sec),  32'd59);
    chk("t2_last_sub",  32'(bus1.o_sub),  32'd1);
    idle(1);
    checkOutput(1, "t2_wrap");
    chk("t2_wrap_hour", 32'(bus1.o_hour), 32'd0);
    chk("t2_wrap_min",  32'(bus1.o_min),  32'd0);
    chk("t2_wrap_sec",  32'(bus1.o_sec),  32'd0);
    chk("t2_wrap_sub",  32'(bus1.o_sub),  32'd0);
    chk("t2_wrap_run",  32'(bus1.o_running), 32'd1);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(1, "t2_stop");

    // 3: fill the lap buffer, then one dropped capture
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "t3_clear");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitFor(0, lapAt[k], -1, 2000);
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput(0, "t3_lap");
    end
    for (int k = 0; k < 2; k++) begin
      idle($urandom_range(1, 30));
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput(0, "t3_lapr");
    end
    chk("t3_cnt", 32'(bus0.o_lap_cnt), 32'd4);
    chk("t3_full", 32'(bus0.o_lap_full), 32'd1);
    idle($urandom_range(1, 30));
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(0, "t3_drop");
    chk("t3_drop_cnt", 32'(bus0.o_lap_cnt), 32'd4);

    // 4: recall ignored in RUN, then step through all laps when stopped
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, "t4_run_recall");
    chk("t4_run_view", 32'(bus0.o_view_lap), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(0, "t4_stop");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput(0, "t4_recall");
      chk("t4_view", 32'(bus0.o_view_lap), 32'(expView[k]));
      chk("t4_idx",  32'(bus0.o_lap_idx),  32'(expIdx[k]));
    end

    // 5: clear beats runstop; lap on a tick edge stores the pre-tick value
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "t5_clr_rs");
    chk("t5_running", 32'(bus0.o_running), 32'd0);
    chk("t5_cnt", 32'(bus0.o_lap_cnt), 32'd0);
    chk("t5_sub", 32'(bus0.o_sub), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitFor(0, 9, 9, 500);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(0, "t5_tick_lap");
    chk("t5_live_sub", 32'(bus0.o_sub), 32'd10);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, "t5_view");
    chk("t5_lap_sub", 32'(bus0.o_sub), 32'd9);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, "t5_back_live");

    // 6: asynchronous reset mid-run, then clear ignored in RUN
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitFor(0, 350, -1, 5000);
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput(0, "t6_async");
    checkOutput(1, "t6_async1");
    chk("t6_sec", 32'(bus0.o_sec), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    checkOutput(0, "t6_release");
    chk("t6_running", 32'(bus0.o_running), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle($urandom_range(20, 80));
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "t6_run_clear");
    chk("t6_run_clear_run", 32'(bus0.o_running), 32'd1);

    // Random pulse mix against the reference
    for (int k = 0; k < 400; k++) begin
      bus0.i_runstop = ($urandom_range(0, 29) == 0);
      bus0.i_clear   = ($urandom_range(0, 9) == 0);
      bus0.i_lap     = ($urandom_range(0, 5) == 0);
      bus0.i_recall  = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      checkOutput(0, "rand");
    end
    setInputs(0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
